pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter RESET_CYCLES, default 16: cycles pll_resetb is held low per PLL reset attempt (min 2).
REQ-002 Parameter LOCK_TIMEOUT, default 4096: cycles allowed in WAIT for lock before retry (min 4).
REQ-003 Parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before releasing system reset (min 1).
REQ-004 Parameter MAX_RETRIES, default 3: failed lock attempts before FAULT (1..15); used only with the REQ-030 macro.
REQ-005 clock  input  1  12 MHz board reference clock (same net as the PLL REFERENCECLK); all logic is on its rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 locked  input  1  PLL LOCK, asynchronous to clock.
REQ-008 restart  input  1  single-cycle request to restart the full sequence.
REQ-009 pll_resetb  output  1  drives PLL RESETB; low = PLL held in reset.
REQ-010 sys_reset_n  output  1  active-low reset for logic on the PLL output clock domain.
REQ-011 fault  output  1  high = lock could not be obtained; sequencer halted.
REQ-012 loss_count  output  8  saturating count of lock losses seen in RUN.

Function
REQ-013 locked SHALL pass through a 2-flop synchronizer; lock_s is the second flop; all decisions use lock_s only (2-cycle input latency).
REQ-014 States: HOLD, WAIT, SETTLE, RUN, FAULT; all outputs registered, decoded from next state so they are valid in the first cycle of each state.
REQ-015 HOLD: pll_resetb=0, sys_reset_n=0; after exactly RESET_CYCLES cycles in HOLD -> WAIT, cycle counter cleared.
REQ-016 WAIT: pll_resetb=1, sys_reset_n=0; lock_s=1 -> SETTLE, counter cleared; else on the LOCK_TIMEOUT-th WAIT cycle -> retry (REQ-019).
REQ-017 SETTLE: pll_resetb=1, sys_reset_n=0; lock_s=0 -> WAIT, counter cleared, no retry charged; STABLE_CYCLES consecutive lock_s=1 cycles -> RUN.
REQ-018 RUN: pll_resetb=1, sys_reset_n=1, retry counter cleared on entry; lock_s=0 -> HOLD, sys_reset_n low from the next cycle, loss_count += 1 saturating at 255.
REQ-019 Retry: retry counter (4 bits) increments; next state is HOLD, or FAULT per REQ-030.
REQ-020 FAULT: pll_resetb=0, sys_reset_n=0, fault=1; left only by restart or reset_n.
REQ-021 restart=1 in any state SHALL force HOLD next cycle, clear the cycle and retry counters and fault; loss_count is kept.
REQ-022 Priority per cycle: reset_n > restart > lock_s transition > timeout/count expiry; lock_s=1 on the timeout cycle SHALL go to SETTLE, not retry.
REQ-023 Counters SHALL be sized to clog2 of the largest of RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES plus 1 and never wrap within a state.
REQ-024 restart held high SHALL keep the block in HOLD, counter at zero.

Reset
REQ-025 On reset_n=0 at a rising edge: state HOLD, synchronizer flops 0, counters 0, retry counter 0.
REQ-026 Reset output values: pll_resetb=0, sys_reset_n=0, fault=0, loss_count=0.
REQ-027 Reset asserted mid-sequence (any state) SHALL take effect at the next edge, discarding all progress.
REQ-028 After reset_n returns high, HOLD SHALL last a full RESET_CYCLES cycles.

Configuration
REQ-029 Macro name: PLL_RESET_SEQUENCER_RETRY_LIMIT_EN.
REQ-030 Defined: the retry reaching MAX_RETRIES -> FAULT. Undefined: retries always -> HOLD, fault tied 0, retry counter absent (retries forever).

Verification (RESET_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8, MAX_RETRIES=2, macro defined unless stated)
REQ-031 Release reset, locked=1 from cycle 0 -> pll_resetb rises after 4 cycles; sys_reset_n rises exactly 4+2+1+8 cycles (±1 per synchronizer edge) later, fault=0.
REQ-032 In RUN drop locked for 3 cycles -> sys_reset_n low 2-3 cycles later, pll_resetb low 4 cycles, loss_count=1, full resequence to RUN.
REQ-033 locked held 0 -> two HOLD/WAIT cycles of 4+16, then fault=1, pll_resetb=0; pulse restart -> fault=0, HOLD; macro undefined -> HOLD/WAIT repeats indefinitely, fault=0.
REQ-034 In SETTLE glitch locked low at count 5 -> back to WAIT, no retry charged, RUN entered 8 full stable cycles after lock returns.
REQ-035 lock_s rises on 16th WAIT cycle -> SETTLE, not HOLD; 256 loss events -> loss_count=255.
REQ-036 Assert reset_n low during SETTLE and restart during RUN -> next cycle all outputs at reset/HOLD values per REQ-021/REQ-026.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses PLL RESETB, waits for a stable lock, then releases the system reset.
// Define PLL_RESET_SEQUENCER_RETRY_LIMIT_EN to stop in FAULT after MAX_RETRIES failed lock attempts.
module pll_reset_sequencer #(
   parameter int RESET_CYCLES  = 16,
   parameter int LOCK_TIMEOUT  = 4096,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       locked,
   input  logic       restart,
   output logic       pll_resetb,
   output logic       sys_reset_n,
   output logic       fault,
   output logic [7:0] loss_count
);

   localparam int MAX_AB  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(STABLE_CYCLES - 1);

   if (RESET_CYCLES < 2) begin : g_bad_reset_cycles
      $error("RESET_CYCLES must be at least 2");
   end
   if (LOCK_TIMEOUT < 4) begin : g_bad_lock_timeout
      $error("LOCK_TIMEOUT must be at least 4");
   end
   if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
      $error("STABLE_CYCLES must be at least 1");
   end
   if (MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_bad_max_retries
      $error("MAX_RETRIES must be in 1..15");
   end

   typedef enum logic [2:0] {
      S_HOLD,
      S_WAIT,
      S_SETTLE,
      S_RUN,
      S_FAULT
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       loss_q, loss_d;
   logic             sync1_q, lock_s_q;
   logic             pll_resetb_q, sys_reset_n_q;

`ifdef PLL_RESET_SEQUENCER_RETRY_LIMIT_EN
   localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);
   logic [3:0] retry_q, retry_d;
   logic       fault_q;
`endif

   // Next state: restart beats lock changes, which beat count expiry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      loss_d  = loss_q;
`ifdef PLL_RESET_SEQUENCER_RETRY_LIMIT_EN
      retry_d = retry_q;
`endif
      if (restart) begin
         state_d = S_HOLD;
         cnt_d   = '0;
`ifdef PLL_RESET_SEQUENCER_RETRY_LIMIT_EN
         retry_d = '0;
`endif
      end else begin
         case (state_q)
            S_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  state_d = S_WAIT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_WAIT: begin
               if (lock_s_q) begin
                  state_d = S_SETTLE;
                  cnt_d   = '0;
               end else if (cnt_q == WAIT_LAST) begin
                  state_d = S_HOLD;
                  cnt_d   = '0;
`ifdef PLL_RESET_SEQUENCER_RETRY_LIMIT_EN
                  retry_d = retry_q + 4'd1;
                  if (retry_d >= RETRY_LIMIT) state_d = S_FAULT;
`endif
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_SETTLE: begin
               // A lock glitch here is not a failed attempt, so no retry is charged.
               if (!lock_s_q) begin
                  state_d = S_WAIT;
                  cnt_d   = '0;
               end else if (cnt_q == SETTLE_LAST) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
`ifdef PLL_RESET_SEQUENCER_RETRY_LIMIT_EN
                  retry_d = '0;
`endif
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_RUN: begin
               if (!lock_s_q) begin
                  state_d = S_HOLD;
                  cnt_d   = '0;
                  if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
               end
            end
            S_FAULT: begin
               state_d = S_FAULT;
            end
            default: begin
               state_d = S_HOLD;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they are valid in the first cycle of each state.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync1_q       <= 1'b0;
         lock_s_q      <= 1'b0;
         state_q       <= S_HOLD;
         cnt_q         <= '0;
         loss_q        <= '0;
         pll_resetb_q  <= 1'b0;
         sys_reset_n_q <= 1'b0;
`ifdef PLL_RESET_SEQUENCER_RETRY_LIMIT_EN
         retry_q       <= '0;
         fault_q       <= 1'b0;
`endif
      end else begin
         sync1_q       <= locked;
         lock_s_q      <= sync1_q;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         loss_q        <= loss_d;
         pll_resetb_q  <= (state_d == S_WAIT) || (state_d == S_SETTLE) || (state_d == S_RUN);
         sys_reset_n_q <= (state_d == S_RUN);
`ifdef PLL_RESET_SEQUENCER_RETRY_LIMIT_EN
         retry_q       <= retry_d;
         fault_q       <= (state_d == S_FAULT);
`endif
      end
   end

   assign pll_resetb  = pll_resetb_q;
   assign sys_reset_n = sys_reset_n_q;
   assign loss_count  = loss_q;
`ifdef PLL_RESET_SEQUENCER_RETRY_LIMIT_EN
   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed boundary cases plus random lock/restart/reset traffic
// compared each cycle against a countdown model of the sequencing rules.
module tb_pll_reset_sequencer;

   localparam int RC = 4;
   localparam int LT = 16;
   localparam int SC = 8;
   localparam int MR = 2;
`ifdef PLL_RESET_SEQUENCER_RETRY_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   localparam int P_HOLD   = 0;
   localparam int P_WAIT   = 1;
   localparam int P_SETTLE = 2;
   localparam int P_RUN    = 3;
   localparam int P_FAULT  = 4;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       locked;
   logic       restart;
   logic       pll_resetb;
   logic       sys_reset_n;
   logic       fault;
   logic [7:0] loss_count;

   pll_reset_sequencer #(
      .RESET_CYCLES (RC),
      .LOCK_TIMEOUT (LT),
      .STABLE_CYCLES(SC),
      .MAX_RETRIES  (MR)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .locked     (locked),
      .restart    (restart),
      .pll_resetb (pll_resetb),
      .sys_reset_n(sys_reset_n),
      .fault      (fault),
      .loss_count (loss_count)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: current phase, cycles left in it, lock history, attempt and loss tallies.
   int m_ph      = P_HOLD;
   int m_left    = RC;
   int m_retries = 0;
   int m_loss    = 0;
   bit m_s1      = 1'b0;
   bit m_s2      = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_failed_attempt();
      m_retries++;
      m_left = RC;
      if (LIMIT_EN && m_retries >= MR) m_ph = P_FAULT;
      else m_ph = P_HOLD;
   endtask

   task automatic model_edge();
      bit seen_lock;
      seen_lock = m_s2;
      if (!reset_n) begin
         m_ph = P_HOLD; m_left = RC; m_retries = 0; m_loss = 0;
         m_s1 = 1'b0; m_s2 = 1'b0;
         return;
      end
      m_s2 = m_s1;
      m_s1 = locked;
      if (restart) begin
         m_ph = P_HOLD; m_left = RC; m_retries = 0;
         return;
      end
      case (m_ph)
         P_HOLD: begin
            m_left--;
            if (m_left == 0) begin m_ph = P_WAIT; m_left = LT; end
         end
         P_WAIT: begin
            if (seen_lock) begin
               m_ph = P_SETTLE; m_left = SC;
            end else begin
               m_left--;
               if (m_left == 0) model_failed_attempt();
            end
         end
         P_SETTLE: begin
            if (!seen_lock) begin
               m_ph = P_WAIT; m_left = LT;
            end else begin
               m_left--;
               if (m_left == 0) begin m_ph = P_RUN; m_retries = 0; end
            end
         end
         P_RUN: begin
            if (!seen_lock) begin
               m_ph = P_HOLD; m_left = RC;
               if (m_loss < 255) m_loss++;
            end
         end
         default: ;
      endcase
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      chk("pll_resetb", 32'(pll_resetb),
          32'(m_ph == P_WAIT || m_ph == P_SETTLE || m_ph == P_RUN));
      chk("sys_reset_n", 32'(sys_reset_n), 32'(m_ph == P_RUN));
      chk("fault", 32'(fault), 32'(LIMIT_EN && m_ph == P_FAULT));
      chk("loss_count", 32'(loss_count), 32'(m_loss));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int tp, ts, mode, len;
      reset_n = 1'b0;
      locked  = 1'b1;
      restart = 1'b0;

      // Reset state
      repeat (3) step();
      chk("rst_pll_resetb", 32'(pll_resetb), 0);
      chk("rst_sys_reset_n", 32'(sys_reset_n), 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_loss_count", 32'(loss_count), 0);

      // Lock present from release: HOLD 4, lock already synced during HOLD, WAIT 1, SETTLE 8.
      reset_n = 1'b1;
      tp = -1; ts = -1;
      for (int i = 1; i <= 60; i++) begin
         step();
         if (pll_resetb && tp < 0) tp = i;
         if (sys_reset_n && ts < 0) ts = i;
      end
      chk("pll_resetb_rise_cycle", 32'(tp), 4);
      chk("sys_reset_n_rise_cycle", 32'(ts), 13);

      // Lock lost for 3 cycles while running: one loss, full resequence.
      locked = 1'b0;
      repeat (3) step();
      locked = 1'b1;
      repeat (40) step();
      chk("loss_after_drop", 32'(loss_count), 1);
      chk("rerun_after_drop", 32'(sys_reset_n), 1);

      // No lock ever: two 4+16 attempts, then FAULT when the limit is built in.
      reset_n = 1'b0;
      locked  = 1'b0;
      step();
      reset_n = 1'b1;
      repeat (39) step();
      chk("fault_before_limit", 32'(fault), 0);
      step();
      chk("fault_at_limit", 32'(fault), 32'(LIMIT_EN));
      repeat (30) step();
      chk("fault_held", 32'(fault), 32'(LIMIT_EN));
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("restart_clears_fault", 32'(fault), 0);
      chk("restart_pll_in_reset", 32'(pll_resetb), 0);

      // Lock seen on the 16th WAIT cycle wins over the timeout.
      repeat (17) step();
      locked = 1'b1;
      repeat (3) step();
      chk("timeout_cycle_lock_settles", 32'(pll_resetb), 1);

      // One-cycle glitch in SETTLE: back to WAIT, no retry, then a full stable run.
      repeat (4) step();
      locked = 1'b0;
      step();
      locked = 1'b1;
      repeat (30) step();
      chk("run_after_settle_glitch", 32'(sys_reset_n), 1);

      // Reset during SETTLE, then restart during RUN, then restart held.
      locked = 1'b0;
      repeat (3) step();
      locked = 1'b1;
      for (int i = 0; i < 60 && m_ph != P_SETTLE; i++) step();
      reset_n = 1'b0;
      step();
      chk("settle_reset_pll", 32'(pll_resetb), 0);
      chk("settle_reset_sys", 32'(sys_reset_n), 0);
      chk("settle_reset_loss", 32'(loss_count), 0);
      reset_n = 1'b1;
      for (int i = 0; i < 60 && !sys_reset_n; i++) step();
      chk("run_reached", 32'(sys_reset_n), 1);
      restart = 1'b1;
      step();
      chk("restart_in_run_sys", 32'(sys_reset_n), 0);
      chk("restart_in_run_pll", 32'(pll_resetb), 0);
      repeat (12) step();
      chk("restart_held_pll", 32'(pll_resetb), 0);
      restart = 1'b0;

      // Random lock behaviour with occasional restart and reset pulses.
      for (int seg = 0; seg < 150; seg++) begin
         mode = int'($urandom_range(0, 3));
         len  = int'($urandom_range(1, 50));
         for (int k = 0; k < len; k++) begin
            case (mode)
               0:       locked = 1'b1;
               1:       locked = 1'b0;
               2:       locked = 1'($urandom_range(0, 1));
               default: locked = ($urandom_range(0, 9) != 0);
            endcase
            restart = ($urandom_range(0, 149) == 0);
            reset_n = ($urandom_range(0, 499) != 0);
            step();
         end
      end
      reset_n = 1'b1;
      locked  = 1'b1;
      restart = 1'b1;
      step();
      restart = 1'b0;

      // Loss counter saturates at 255.
      for (int ev = 0; ev < 260; ev++) begin
         for (int i = 0; i < 60 && !sys_reset_n; i++) step();
         locked = 1'b0;
         for (int i = 0; i < 10 && sys_reset_n; i++) step();
         locked = 1'b1;
      end
      for (int i = 0; i < 60 && !sys_reset_n; i++) step();
      chk("loss_saturated", 32'(loss_count), 255);
      chk("run_after_saturation", 32'(sys_reset_n), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
